// File: rtl/jk_pkg.sv
// Shared definitions for the JK universal register: mode encodings and mode width.
package jk_pkg;

    localparam int JK_MODE_W = 3;

    localparam logic [JK_MODE_W-1:0] JK_HOLD = 3'b000;
    localparam logic [JK_MODE_W-1:0] JK_JK   = 3'b001;
    localparam logic [JK_MODE_W-1:0] JK_LOAD = 3'b010;
    localparam logic [JK_MODE_W-1:0] JK_SHL  = 3'b011;
    localparam logic [JK_MODE_W-1:0] JK_SHR  = 3'b100;
    localparam logic [JK_MODE_W-1:0] JK_UP   = 3'b101;
    localparam logic [JK_MODE_W-1:0] JK_DOWN = 3'b110;
    localparam logic [JK_MODE_W-1:0] JK_INV  = 3'b111;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop bit with asynchronous active-low clear.
module jk_cell (
    input  logic clk,
    input  logic clr,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qn
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({J, K})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    assign Qn = ~q_q;

endmodule

// File: rtl/jk_universal_register.sv
// WIDTH-bit register of JK cells: hold, JK, load, shift, modulo up/down count, invert.
// Every mode is reduced to per-bit J/K drive; the cells hold the only state.
module jk_universal_register
    import jk_pkg::*;
#(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 en,
    input  logic [JK_MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]     J,
    input  logic [WIDTH-1:0]     K,
    input  logic [WIDTH-1:0]     d,
    input  logic                 sin,
    output logic [WIDTH-1:0]     Q,
    output logic [WIDTH-1:0]     Qn,
    output logic                 sout,
    output logic                 tc
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("jk_universal_register: WIDTH must be in 2..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
        $error("jk_universal_register: MODULUS must be in 2..2**WIDTH");
    end

    // Compares run one bit wider so MODULUS == 2**WIDTH stays representable.
    localparam longint unsigned MAX_L = MODULUS - 64'd1;
    localparam logic [WIDTH:0]   MOD_W = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   MAX_W = MAX_L[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_Q = MAX_L[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_Q = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] j_v;
    logic [WIDTH-1:0] k_v;

    assign q_ext = {1'b0, q_w};

    always_comb begin
        tgt = q_w;
        j_v = '0;
        k_v = '0;
        if (en) begin
            case (mode)
                JK_JK: begin
                    j_v = J;
                    k_v = K;
                end
                JK_LOAD, JK_SHL, JK_SHR, JK_UP, JK_DOWN: begin
                    case (mode)
                        JK_LOAD: tgt = d;
                        JK_SHL:  tgt = {q_w[WIDTH-2:0], sin};
                        JK_SHR:  tgt = {sin, q_w[WIDTH-1:1]};
                        JK_UP:   tgt = (q_ext >= MAX_W) ? '0 : q_w + ONE_Q;
                        default: tgt = (q_w == '0 || q_ext >= MOD_W) ? MAX_Q : q_w - ONE_Q;
                    endcase
                    j_v = tgt;
                    k_v = ~tgt;
                end
                JK_INV: begin
                    j_v = '1;
                    k_v = '1;
                end
                default: begin
                    j_v = '0;
                    k_v = '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .clr (clr),
            .J   (j_v[i]),
            .K   (k_v[i]),
            .Q   (q_w[i]),
            .Qn  (qn_w[i])
        );
    end

    always_comb begin
        sout = 1'b0;
        tc   = 1'b0;
        if (mode == JK_SHL) begin
            sout = q_w[WIDTH-1];
        end else if (mode == JK_SHR) begin
            sout = q_w[0];
        end
        if (en) begin
            if (mode == JK_UP && q_w == MAX_Q) begin
                tc = 1'b1;
            end else if (mode == JK_DOWN && q_w == '0) begin
                tc = 1'b1;
            end
        end
    end

    assign Q  = q_w;
    assign Qn = qn_w;

endmodule

// File: tb/tb_jk_universal_register.sv
module tb_jk_universal_register;
  import jk_pkg::*;

  logic       clk;
  logic       clr;
  logic       en;
  logic [2:0] mode;
  logic [3:0] J;
  logic [3:0] K;
  logic [3:0] d;
  logic       sin;
  logic [3:0] Q;
  logic [3:0] Qn;
  logic       sout;
  logic       tc;

  logic       cclr;
  logic [2:0] cmode;
  logic [3:0] lo_q, lo_qn, hi_q, hi_qn;
  logic       lo_sout, lo_tc, hi_sout, hi_tc;

  int n_chk  = 0;
  int n_pass = 0;

  jk_universal_register #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .clr(clr), .en(en), .mode(mode), .J(J), .K(K), .d(d), .sin(sin),
    .Q(Q), .Qn(Qn), .sout(sout), .tc(tc)
  );

  jk_universal_register #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .clr(cclr), .en(1'b1), .mode(cmode), .J(4'h0), .K(4'h0), .d(4'h0), .sin(1'b0),
    .Q(lo_q), .Qn(lo_qn), .sout(lo_sout), .tc(lo_tc)
  );

  jk_universal_register #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .clr(cclr), .en(lo_tc), .mode(cmode), .J(4'h0), .K(4'h0), .d(4'h0), .sin(1'b0),
    .Q(hi_q), .Qn(hi_qn), .sout(hi_sout), .tc(hi_tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic res(input string nm, input bit ok, input logic [31:0] got, input logic [31:0] e);
    n_chk++;
    if (ok) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, got, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic [3:0] dv);
    mode = m;
    d    = dv;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    clr = 1'b0; en = 1'b1; mode = JK_HOLD; J = '0; K = '0; d = '0; sin = 1'b0;
    cclr = 1'b0; cmode = JK_UP;
    #1;
    res("rst_q", Q === 4'h0, Q, 32'h0);
    res("rst_qn", Qn === 4'hF, Qn, 32'hF);
    res("rst_sout", sout === 1'b0, sout, 32'h0);
    mode = JK_DOWN;
    #1;
    res("rst_tc_down", tc === 1'b1, tc, 32'h1);
    mode = JK_UP;
    #1;
    res("rst_tc_up", tc === 1'b0, tc, 32'h0);

    clr = 1'b1;
    op(JK_LOAD, 4'b1011);
    res("load_1011", Q === 4'hB, Q, 32'hB);
    clr = 1'b0;
    #1;
    res("async_clr_q", Q === 4'h0, Q, 32'h0);
    res("async_clr_qn", Qn === 4'hF, Qn, 32'hF);
    op(JK_LOAD, 4'b1111);
    op(JK_LOAD, 4'b1111);
    res("clr_held_load", Q === 4'h0, Q, 32'h0);
    clr = 1'b1;

    op(JK_LOAD, 4'b0101);
    J = 4'b1100; K = 4'b1010;
    op(JK_JK, 4'h0);
    res("jk_mix", Q === 4'hD, Q, 32'hD);
    op(JK_INV, 4'h0);
    res("inv", Q === 4'h2, Q, 32'h2);
    res("inv_qn", Qn === 4'hD, Qn, 32'hD);
    en = 1'b0;
    op(JK_LOAD, 4'hF);
    op(JK_INV, 4'hF);
    res("en_low_hold", Q === 4'h2, Q, 32'h2);
    en = 1'b1;
    op(JK_HOLD, 4'hF);
    res("hold", Q === 4'h2, Q, 32'h2);

    op(JK_LOAD, 4'd7);
    op(JK_UP, 4'd0);
    res("up_8", Q === 4'd8, Q, 32'd8);
    res("up_tc_8", tc === 1'b0, tc, 32'h0);
    op(JK_UP, 4'd0);
    res("up_9", Q === 4'd9, Q, 32'd9);
    res("up_tc_9", tc === 1'b1, tc, 32'h1);
    en = 1'b0;
    #1;
    res("up_tc_en0", tc === 1'b0, tc, 32'h0);
    en = 1'b1;
    op(JK_UP, 4'd0);
    res("up_wrap_0", Q === 4'd0, Q, 32'd0);
    res("up_tc_0", tc === 1'b0, tc, 32'h0);
    op(JK_UP, 4'd0);
    res("up_1", Q === 4'd1, Q, 32'd1);
    op(JK_LOAD, 4'd12);
    mode = JK_UP;
    #1;
    res("up_tc_oor", tc === 1'b0, tc, 32'h0);
    op(JK_UP, 4'd0);
    res("up_oor_0", Q === 4'd0, Q, 32'd0);

    op(JK_LOAD, 4'd1);
    op(JK_DOWN, 4'd0);
    res("dn_0", Q === 4'd0, Q, 32'd0);
    res("dn_tc_0", tc === 1'b1, tc, 32'h1);
    op(JK_DOWN, 4'd0);
    res("dn_9", Q === 4'd9, Q, 32'd9);
    res("dn_tc_9", tc === 1'b0, tc, 32'h0);
    op(JK_DOWN, 4'd0);
    res("dn_8", Q === 4'd8, Q, 32'd8);
    op(JK_LOAD, 4'd14);
    op(JK_DOWN, 4'd0);
    res("dn_oor_9", Q === 4'd9, Q, 32'd9);

    op(JK_LOAD, 4'b1001);
    mode = JK_SHL; sin = 1'b0;
    #1;
    res("shl_sout", sout === 1'b1, sout, 32'h1);
    step();
    res("shl_q", Q === 4'h2, Q, 32'h2);
    mode = JK_SHR; sin = 1'b1;
    #1;
    res("shr_sout", sout === 1'b0, sout, 32'h0);
    step();
    res("shr_q", Q === 4'h9, Q, 32'h9);
    res("shr_sout_after", sout === 1'b1, sout, 32'h1);

    cclr = 1'b1;
    for (int i = 0; i < 25; i++) step();
    res("casc_hi_25", hi_q === 4'd2, hi_q, 32'd2);
    res("casc_lo_25", lo_q === 4'd5, lo_q, 32'd5);
    res("casc_lo_tc_25", lo_tc === 1'b0, lo_tc, 32'h0);
    res("casc_qn_25", {hi_qn, lo_qn} === 8'hDA, {hi_qn, lo_qn}, 32'hDA);
    res("casc_sout", {hi_sout, lo_sout} === 2'b00, {hi_sout, lo_sout}, 32'h0);
    for (int i = 0; i < 74; i++) step();
    res("casc_hi_99", hi_q === 4'd9, hi_q, 32'd9);
    res("casc_lo_99", lo_q === 4'd9, lo_q, 32'd9);
    res("casc_lo_tc_99", lo_tc === 1'b1, lo_tc, 32'h1);
    res("casc_hi_tc_99", hi_tc === 1'b1, hi_tc, 32'h1);
    step();
    res("casc_hi_00", hi_q === 4'd0, hi_q, 32'd0);
    res("casc_lo_00", lo_q === 4'd0, lo_q, 32'd0);
    res("casc_hi_tc_00", hi_tc === 1'b0, hi_tc, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
